// File: rtl/line_mem_responder.sv
// Cache-line memory responder: serves one read or write of a DATA_W-bit line per request
// after a fixed LATENCY, acknowledging with a one-cycle ack pulse and flagging out-of-range lines.
module line_mem_responder #(
  parameter int DATA_W      = 256,
  parameter int DEPTH       = 512,
  parameter int OFFSET_BITS = 5,
  parameter int LATENCY     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o
);

  // Handshake: the initiator raises enable_i and keeps addr_i/data_i/write_i stable until it
  // sees ack_o. A request is sampled only in IDLE; the ACK cycle never samples enable_i.

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [31:0]        addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               write_q;
  logic               go_ack;

  logic [DATA_W-1:0]  memory [DEPTH];

  // With LATENCY==1 the ACK edge is also the sample edge, so IDLE uses the live inputs.
  logic [31:0]        req_addr;
  logic [DATA_W-1:0]  req_data;
  logic               req_write;
  logic [31:0]        req_line;
  logic               req_in_range;
  logic [IDX_W-1:0]   req_idx;
  logic               mem_we;

  assign req_addr     = (state == IDLE) ? addr_i  : addr_q;
  assign req_data     = (state == IDLE) ? data_i  : data_q;
  assign req_write    = (state == IDLE) ? write_i : write_q;
  assign req_line     = req_addr >> OFFSET_BITS;
  assign req_in_range = (req_line < 32'(DEPTH));
  assign req_idx      = req_addr[OFFSET_BITS +: IDX_W];
  assign mem_we       = go_ack && req_write && req_in_range && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          if (LATENCY == 1) begin
            state_n = ACK;
            go_ack  = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      if (state == IDLE && enable_i) begin
        addr_q  <= addr_i;
        data_q  <= data_i;
        write_q <= write_i;
      end
      ack_o  <= go_ack;
      err_o  <= go_ack && !req_in_range;
      busy_o <= (state_n != IDLE);
      if (go_ack) begin
        if (!req_in_range)
          data_o <= '0;
        else if (!req_write)
          data_o <= memory[req_idx];
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (mem_we)
      memory[req_idx] <= req_data;
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=10 instance for the main scenarios
// and a LATENCY=1 instance for the minimum-latency back-to-back case.
module tb_line_mem_responder;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, wr;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic         ack, busy, err;

  logic         rst_1, en_1, wr_1;
  logic [31:0]  addr_1;
  logic [255:0] wdata_1, rdata_1;
  logic         ack_1, busy_1, err_1;

  int checks = 0;
  int fails  = 0;

  localparam logic [255:0] PAT_A = {8{32'hDEADBEEF}};
  localparam logic [255:0] PAT_B = {8{32'h12345678}};

  line_mem_responder #(.DATA_W(256), .DEPTH(512), .OFFSET_BITS(5), .LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(en), .write_i(wr),
    .ack_o(ack), .data_o(rdata), .busy_o(busy), .err_o(err)
  );

  line_mem_responder #(.DATA_W(256), .DEPTH(512), .OFFSET_BITS(5), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_1), .addr_i(addr_1), .data_i(wdata_1), .enable_i(en_1), .write_i(wr_1),
    .ack_o(ack_1), .data_o(rdata_1), .busy_o(busy_1), .err_o(err_1)
  );

  // Counts edges from now until ack is seen (sampled 1 time unit after each edge), bounded.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack !== 1'b1 && n < 40);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ack !== 1'b0)   begin $display("FAIL reset_ack: got %0b want 0", ack); fails++; end
    checks++; if (busy !== 1'b0)  begin $display("FAIL reset_busy: got %0b want 0", busy); fails++; end
    checks++; if (err !== 1'b0)   begin $display("FAIL reset_err: got %0b want 0", err); fails++; end
    checks++; if (rdata !== '0)   begin $display("FAIL reset_data: got %h want 0", rdata); fails++; end
    checks++; if (ack_1 !== 1'b0) begin $display("FAIL reset_ack_l1: got %0b want 0", ack_1); fails++; end
    @(posedge clk); #1;
    rst = 1'b0; rst_1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_latency();
    logic exp_ack, exp_busy;
    dut.memory[0] = 256'h5;
    wr = 1'b0; addr = 32'h0; en = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk); #1;
      exp_ack  = (e == 10);
      exp_busy = (e <= 10);
      checks++; if (ack !== exp_ack)
        begin $display("FAIL rd_ack edge %0d: got %0b want %0b", e, ack, exp_ack); fails++; end
      checks++; if (busy !== exp_busy)
        begin $display("FAIL rd_busy edge %0d: got %0b want %0b", e, busy, exp_busy); fails++; end
      if (e == 10) begin
        checks++; if (rdata !== 256'h5) begin $display("FAIL rd_data: got %h want 5", rdata); fails++; end
        en = 1'b0;
      end
    end
  endtask

  task automatic test_write_then_read();
    int n;
    addr = 32'h400; wdata = PAT_A; wr = 1'b1; en = 1'b1;
    wait_ack(n);
    checks++; if (n !== 10) begin $display("FAIL wr_latency: got %0d want 10", n); fails++; end
    checks++; if (dut.memory[32] !== PAT_A) begin $display("FAIL wr_mem32: got %h want %h", dut.memory[32], PAT_A); fails++; end
    checks++; if (err !== 1'b0) begin $display("FAIL wr_err: got %0b want 0", err); fails++; end
    // Read request presented during the ACK cycle: first sample is on the next IDLE edge.
    wr = 1'b0; wdata = '0;
    wait_ack(n);
    checks++; if (n !== 11) begin $display("FAIL b2b_latency: got %0d want 11", n); fails++; end
    checks++; if (rdata !== PAT_A) begin $display("FAIL rdback_data: got %h want %h", rdata, PAT_A); fails++; end
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    int n;
    addr = 32'h4000; wr = 1'b0; en = 1'b1;
    wait_ack(n);
    checks++; if (n !== 10) begin $display("FAIL oor_latency: got %0d want 10", n); fails++; end
    checks++; if (err !== 1'b1) begin $display("FAIL oor_err: got %0b want 1", err); fails++; end
    checks++; if (rdata !== '0) begin $display("FAIL oor_data: got %h want 0", rdata); fails++; end
    en = 1'b0;
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin $display("FAIL oor_err_clear: got %0b want 0", err); fails++; end
    wr = 1'b1; wdata = '1; en = 1'b1;
    wait_ack(n);
    checks++; if (err !== 1'b1) begin $display("FAIL oor_wr_err: got %0b want 1", err); fails++; end
    checks++; if (dut.memory[0] !== 256'h5) begin $display("FAIL oor_alias: got %h want 5", dut.memory[0]); fails++; end
    en = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ack_ignores_enable();
    int n;
    dut.memory[1] = 256'h11;
    dut.memory[2] = 256'h22;
    addr = 32'h0; wr = 1'b0; en = 1'b1;
    wait_ack(n);
    checks++; if (rdata !== 256'h5) begin $display("FAIL ign_first_data: got %h want 5", rdata); fails++; end
    addr = 32'h20;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin $display("FAIL ign_ack_sampled: busy got %0b want 0", busy); fails++; end
    addr = 32'h40;
    wait_ack(n);
    checks++; if (n !== 10) begin $display("FAIL ign_latency: got %0d want 10", n); fails++; end
    checks++; if (rdata !== 256'h22) begin $display("FAIL ign_data: got %h want 22", rdata); fails++; end
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int n, acks;
    dut.memory[7] = 256'h77;
    addr = 32'hE0; wdata = PAT_B; wr = 1'b1; en = 1'b1;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; #1;
    checks++; if (ack !== 1'b0) begin $display("FAIL rst_ack: got %0b want 0", ack); fails++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %0b want 0", busy); fails++; end
    checks++; if (rdata !== '0) begin $display("FAIL rst_data: got %h want 0", rdata); fails++; end
    checks++; if (dut.state !== 2'd0) begin $display("FAIL rst_state: got %0d want 0", dut.state); fails++; end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    acks = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin $display("FAIL rst_late_ack: got %0d acks want 0", acks); fails++; end
    checks++; if (dut.memory[7] !== 256'h77) begin $display("FAIL rst_mem7: got %h want 77", dut.memory[7]); fails++; end
    en = 1'b1;
    wait_ack(n);
    checks++; if (n !== 10) begin $display("FAIL reissue_latency: got %0d want 10", n); fails++; end
    checks++; if (dut.memory[7] !== PAT_B) begin $display("FAIL reissue_mem7: got %h want %h", dut.memory[7], PAT_B); fails++; end
    en = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency1_back_to_back();
    logic exp_ack;
    logic [255:0] exp_data;
    dut1.memory[3] = 256'h33;
    dut1.memory[4] = 256'h44;
    addr_1 = 32'h60; wr_1 = 1'b0; en_1 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      exp_ack = (e == 1 || e == 3);
      checks++; if (ack_1 !== exp_ack)
        begin $display("FAIL l1_ack edge %0d: got %0b want %0b", e, ack_1, exp_ack); fails++; end
      checks++; if (busy_1 !== exp_ack)
        begin $display("FAIL l1_busy edge %0d: got %0b want %0b", e, busy_1, exp_ack); fails++; end
      if (exp_ack) begin
        exp_data = (e == 1) ? 256'h33 : 256'h44;
        checks++; if (rdata_1 !== exp_data)
          begin $display("FAIL l1_data edge %0d: got %h want %h", e, rdata_1, exp_data); fails++; end
      end
      if (e == 2) addr_1 = 32'h80;
      if (e == 4) en_1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rst_1 = 1'b1; en_1 = 1'b0; wr_1 = 1'b0; addr_1 = '0; wdata_1 = '0;
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_out_of_range();
    test_ack_ignores_enable();
    test_reset_mid_wait();
    test_latency1_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
